// File: rtl/alarm_pkg.sv
// alarm_pkg: shared encodings and limits for the multi-channel alarm controller.
package alarm_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_EN = 2'd3} edit_e;
    typedef enum logic [1:0] {ARMED = 2'd0, RINGING = 2'd1, SNOOZED = 2'd2} phase_e;
    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN = 6'd59;
endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm time with enable, edge-triggered ring and snooze countdown.
// ALARM_RING_TIMEOUT_EN adds a per-channel auto-stop after RING_TIMEOUT_MIN ringing minutes.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 5
`ifdef ALARM_RING_TIMEOUT_EN
    ,
    parameter int RING_TIMEOUT_MIN = 10
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_hour_i,
    input  logic       inc_min_i,
    input  logic       tog_en_i,
    input  logic       suppress_i,
    input  logic       snooze_i,
    input  logic       stop_i,
    input  logic       tick_i,
    input  logic [4:0] curr_hour_i,
    input  logic [5:0] curr_min_i,
    output logic [4:0] hour_o,
    output logic [5:0] min_o,
    output logic       en_o,
    output logic       ring_o
);
    logic [4:0] hour_q, hour_d;
    logic [5:0] min_q, min_d;
    logic       en_q, en_d, prev_q, match;
    phase_e     phase_q, phase_d;
    logic [3:0] cnt_q, cnt_d;
`ifdef ALARM_RING_TIMEOUT_EN
    logic [3:0] rcnt_q, rcnt_d;
`endif

    always_comb begin
        match   = en_q && curr_hour_i == hour_q && curr_min_i == min_q && !suppress_i;
        hour_d  = inc_hour_i ? (hour_q == MAX_HOUR ? 5'd0 : hour_q + 5'd1) : hour_q;
        min_d   = inc_min_i ? (min_q == MAX_MIN ? 6'd0 : min_q + 6'd1) : min_q;
        en_d    = en_q ^ tog_en_i;
        phase_d = phase_q;
        cnt_d   = cnt_q;
`ifdef ALARM_RING_TIMEOUT_EN
        rcnt_d  = rcnt_q;
`endif
        // disabling counts as a stop so a switched-off channel never keeps ringing
        if (stop_i || (tog_en_i && en_q)) phase_d = ARMED;
        else if (snooze_i && phase_q == RINGING) begin
            phase_d = SNOOZED;
            cnt_d   = 4'(SNOOZE_MIN);
        end else if (phase_q == ARMED && match && !prev_q) phase_d = RINGING;
        else if (phase_q == SNOOZED && tick_i) begin
            cnt_d   = cnt_q - 4'd1;
            phase_d = cnt_d == 4'd0 ? RINGING : SNOOZED;
        end
`ifdef ALARM_RING_TIMEOUT_EN
        else if (phase_q == RINGING && tick_i) begin
            rcnt_d  = rcnt_q + 4'd1;
            phase_d = rcnt_d == 4'(RING_TIMEOUT_MIN) ? ARMED : RINGING;
        end
        if (phase_d == RINGING && phase_q != RINGING) rcnt_d = 4'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_q  <= '0;
            min_q   <= '0;
            en_q    <= 1'b0;
            prev_q  <= 1'b0;
            phase_q <= ARMED;
            cnt_q   <= '0;
`ifdef ALARM_RING_TIMEOUT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            hour_q  <= hour_d;
            min_q   <= min_d;
            en_q    <= en_d;
            prev_q  <= match;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
`ifdef ALARM_RING_TIMEOUT_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    assign hour_o = hour_q;
    assign min_o  = min_q;
    assign en_o   = en_q;
    assign ring_o = phase_q == RINGING;
endmodule

// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: N alarm channels sharing one button-driven edit FSM and display mux.
// Define ALARM_RING_TIMEOUT_EN to auto-stop channels that ring unattended.
module multi_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS       = 4,
    parameter int SEL_W            = 2,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_mode,
    input  logic                  btn_set,
    input  logic                  btn_sel,
    input  logic                  btn_snooze,
    input  logic                  btn_stop,
    input  logic                  min_tick,
    input  logic [4:0]            curr_hour,
    input  logic [5:0]            curr_min,
    output logic [SEL_W-1:0]      sel_idx,
    output logic [1:0]            edit_state,
    output logic [4:0]            disp_hour,
    output logic [5:0]            disp_min,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic [NUM_ALARMS-1:0] ring_vec,
    output logic                  alarm_on
);
    edit_e            edit_q, edit_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [1:0]       edit_out_q;
    logic [4:0]       disp_hour_q;
    logic [5:0]       disp_min_q;
    logic [4:0]       hour_w [NUM_ALARMS];
    logic [5:0]       min_w  [NUM_ALARMS];

    if (NUM_ALARMS < 1 || NUM_ALARMS > 8 || SEL_W < 1 || (1 << SEL_W) < NUM_ALARMS ||
        SNOOZE_MIN < 1 || SNOOZE_MIN > 15 || RING_TIMEOUT_MIN < 1 || RING_TIMEOUT_MIN > 15) begin : g_bad_param
        $error("multi_alarm_ctrl: parameter out of range");
    end

    always_comb begin
        edit_d = btn_mode ? edit_e'(edit_q + 2'd1) : edit_q;
        sel_d  = (edit_q == IDLE && btn_sel) ?
                 (sel_q == SEL_W'(NUM_ALARMS - 1) ? '0 : sel_q + SEL_W'(1)) : sel_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edit_q      <= IDLE;
            sel_q       <= '0;
            edit_out_q  <= '0;
            disp_hour_q <= '0;
            disp_min_q  <= '0;
        end else begin
            edit_q      <= edit_d;
            sel_q       <= sel_d;
            edit_out_q  <= edit_q;
            disp_hour_q <= hour_w[sel_q];
            disp_min_q  <= min_w[sel_q];
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        logic hit;
        assign hit = sel_q == SEL_W'(i);
        alarm_channel #(
            .SNOOZE_MIN(SNOOZE_MIN)
`ifdef ALARM_RING_TIMEOUT_EN
            ,
            .RING_TIMEOUT_MIN(RING_TIMEOUT_MIN)
`endif
        ) u_ch (
            .clk        (clk),
            .rst        (reset),
            .inc_hour_i (btn_set && edit_q == SET_HOUR && hit),
            .inc_min_i  (btn_set && edit_q == SET_MIN && hit),
            .tog_en_i   (btn_set && edit_q == SET_EN && hit),
            .suppress_i (edit_q != IDLE && hit),
            .snooze_i   (btn_snooze),
            .stop_i     (btn_stop),
            .tick_i     (min_tick),
            .curr_hour_i(curr_hour),
            .curr_min_i (curr_min),
            .hour_o     (hour_w[i]),
            .min_o      (min_w[i]),
            .en_o       (alarm_en[i]),
            .ring_o     (ring_vec[i])
        );
    end

    assign sel_idx    = sel_q;
    assign edit_state = edit_out_q;
    assign disp_hour  = disp_hour_q;
    assign disp_min   = disp_min_q;
    assign alarm_on   = |ring_vec;
endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb_multi_alarm_ctrl: directed scoreboard bench for multi_alarm_ctrl (default 4 channels).
module tb_multi_alarm_ctrl;
    localparam int B_MODE = 0, B_SET = 1, B_SEL = 2, B_SNOOZE = 3, B_STOP = 4, B_TICK = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 0, btn_set = 0, btn_sel = 0, btn_snooze = 0, btn_stop = 0, min_tick = 0;
    logic [4:0] curr_hour = 5'd12;
    logic [5:0] curr_min = 6'd0;
    logic [1:0] sel_idx, edit_state;
    logic [4:0] disp_hour;
    logic [5:0] disp_min;
    logic [3:0] alarm_en, ring_vec;
    logic       alarm_on;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int   total = 0, fails = 0;

    multi_alarm_ctrl dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_set(btn_set), .btn_sel(btn_sel),
        .btn_snooze(btn_snooze), .btn_stop(btn_stop), .min_tick(min_tick),
        .curr_hour(curr_hour), .curr_min(curr_min), .sel_idx(sel_idx), .edit_state(edit_state),
        .disp_hour(disp_hour), .disp_min(disp_min), .alarm_en(alarm_en), .ring_vec(ring_vec),
        .alarm_on(alarm_on)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic press(input int b, input int n = 1);
        for (int k = 0; k < n; k++) begin
            case (b)
                B_MODE:   btn_mode = 1;
                B_SET:    btn_set = 1;
                B_SEL:    btn_sel = 1;
                B_SNOOZE: btn_snooze = 1;
                B_STOP:   btn_stop = 1;
                default:  min_tick = 1;
            endcase
            @(negedge clk);
            {btn_mode, btn_set, btn_sel, btn_snooze, btn_stop, min_tick} = '0;
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m);
        curr_hour = h;
        curr_min = m;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        push("rst_sel", 0);     pop_chk(32'(sel_idx));
        push("rst_state", 0);   pop_chk(32'(edit_state));
        push("rst_hour", 0);    pop_chk(32'(disp_hour));
        push("rst_min", 0);     pop_chk(32'(disp_min));
        push("rst_en", 0);      pop_chk(32'(alarm_en));
        push("rst_ring", 0);    pop_chk(32'(ring_vec));
        push("rst_on", 0);      pop_chk(32'(alarm_on));

        // program ch2 to 07:30, enabled
        press(B_SEL, 2);
        press(B_MODE); press(B_SET, 7);
        press(B_MODE); press(B_SET, 30);
        press(B_MODE); press(B_SET);
        press(B_MODE);
        settle();
        push("prog_sel", 2);    pop_chk(32'(sel_idx));
        push("prog_hour", 7);   pop_chk(32'(disp_hour));
        push("prog_min", 30);   pop_chk(32'(disp_min));
        push("prog_en", 4'b0100); pop_chk(32'(alarm_en));
        push("prog_state", 0);  pop_chk(32'(edit_state));

        // wrap checks on ch3, left disabled
        press(B_SEL);
        press(B_MODE);
        settle();
        push("state_hour", 1);  pop_chk(32'(edit_state));
        press(B_SEL);
        settle();
        push("sel_ignored", 3); pop_chk(32'(sel_idx));
        press(B_SET, 23);
        settle();
        push("hour_23", 23);    pop_chk(32'(disp_hour));
        press(B_SET);
        settle();
        push("hour_wrap", 0);   pop_chk(32'(disp_hour));
        press(B_MODE);
        press(B_SET, 59);
        settle();
        push("min_59", 59);     pop_chk(32'(disp_min));
        press(B_SET);
        settle();
        push("min_wrap", 0);    pop_chk(32'(disp_min));
        press(B_MODE, 2);
        press(B_SEL);
        settle();
        push("sel_wrap", 0);    pop_chk(32'(sel_idx));
        push("en_after_wrap", 4'b0100); pop_chk(32'(alarm_en));

        // ring, snooze, re-ring
        set_time(7, 29);
        set_time(7, 30);
        push("ring", 4'b0100);  pop_chk(32'(ring_vec));
        push("ring_on", 1);     pop_chk(32'(alarm_on));
        press(B_SNOOZE);
        push("snoozed", 0);     pop_chk(32'(ring_vec));
        press(B_TICK, 4);
        push("snooze_4tick", 0); pop_chk(32'(ring_vec));
        press(B_TICK);
        push("snooze_expire", 4'b0100); pop_chk(32'(ring_vec));

        // stop beats snooze, no retrigger in the same minute
        btn_stop = 1; btn_snooze = 1;
        @(negedge clk);
        btn_stop = 0; btn_snooze = 0;
        push("stop_prio", 0);   pop_chk(32'(ring_vec));
        press(B_TICK, 6);
        repeat (5) @(negedge clk);
        push("no_retrigger", 0); pop_chk(32'(ring_vec));
        set_time(7, 31);
        set_time(7, 30);
        push("next_day", 4'b0100); pop_chk(32'(ring_vec));
        press(B_STOP);

        // ch0 and ch1 at 06:00
        press(B_MODE); press(B_SET, 6); press(B_MODE, 2); press(B_SET); press(B_MODE);
        press(B_SEL);
        press(B_MODE); press(B_SET, 6); press(B_MODE, 2); press(B_SET); press(B_MODE);
        settle();
        push("en_three", 4'b0111); pop_chk(32'(alarm_en));
        push("two_no_ring", 0); pop_chk(32'(ring_vec));
        set_time(6, 0);
        push("two_ring", 4'b0011); pop_chk(32'(ring_vec));
        press(B_STOP);
        push("two_stop", 0);    pop_chk(32'(alarm_on));
        set_time(6, 1);
        press(B_SEL, 3);
        press(B_MODE);
        settle();
        push("sel_ch0", 0);     pop_chk(32'(sel_idx));
        set_time(6, 0);
        @(negedge clk);
        push("suppress_ch0", 4'b0010); pop_chk(32'(ring_vec));
        set_time(6, 2);
        press(B_STOP);
        press(B_MODE, 3);

        // unattended ringing
        set_time(7, 29);
        set_time(7, 30);
        push("to_ring", 4'b0100); pop_chk(32'(ring_vec));
`ifdef ALARM_RING_TIMEOUT_EN
        press(B_TICK, 9);
        push("to_9tick", 4'b0100); pop_chk(32'(ring_vec));
        press(B_TICK);
        push("to_expired", 0);  pop_chk(32'(ring_vec));
`else
        press(B_TICK, 20);
        push("no_timeout", 4'b0100); pop_chk(32'(ring_vec));
`endif

        // reset mid-ring clears everything
        set_time(7, 31);
        set_time(7, 30);
        press(B_SEL);
        reset = 1;
        @(negedge clk);
        reset = 0;
        push("rst2_ring", 0);   pop_chk(32'(ring_vec));
        push("rst2_en", 0);     pop_chk(32'(alarm_en));
        push("rst2_sel", 0);    pop_chk(32'(sel_idx));

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
